fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 5, instruction-memory address width (32 words).
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 direinstru  output  ADDR_W  address to instruction memory; equals pc register (combinational from pc only).
REQ-007 instru  input  DATA_W  instruction word from instruction memory, combinational on direinstru.
REQ-008 stall  input  1  downstream (ID) cannot accept; hold fetch state.
REQ-009 branch_taken  input  1  redirect request from later stage.
REQ-010 branch_target  input  ADDR_W  redirect address.
REQ-011 halt_req  input  1  stop fetching until reset.
REQ-012 if_instr  output  DATA_W  IF/ID registered instruction.
REQ-013 if_pc  output  ADDR_W  address from which if_instr was fetched.
REQ-014 if_valid  output  1  if_instr/if_pc hold a live instruction.
REQ-015 halted  output  1  high in HALTED state.
REQ-016 fetch_count  output  16  accepted-fetch counter (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, RUN, HALTED; IDLE->RUN unconditionally one cycle after reset deasserts; RUN->HALTED on halt_req; HALTED exits only by reset.
REQ-018 IDLE: pc = RESET_PC, if_valid = 0, no fetch accepted (memory settles).
REQ-019 RUN, no branch, no stall: on the edge, if_instr <= instru, if_pc <= pc, if_valid <= 1, pc <= pc + 1.
REQ-020 pc increment SHALL wrap modulo 2^ADDR_W (31 -> 0), no flag.
REQ-021 RUN with stall=1, branch_taken=0: pc, if_instr, if_pc, if_valid SHALL hold.
REQ-022 branch_taken=1 in RUN SHALL take priority over stall: pc <= branch_target, if_valid <= 0 (squash), if_instr/if_pc hold; fetch from target begins next cycle.
REQ-023 Fetch latency: instruction at address A appears on if_instr with if_valid=1 one edge after direinstru = A with no stall/branch.
REQ-024 halt_req in RUN SHALL take priority over branch and stall: if_valid <= 0, pc holds, halted <= 1.
REQ-025 HALTED: pc, if_instr, if_pc frozen, if_valid = 0; stall/branch ignored.
REQ-026 branch_taken, stall, halt_req in IDLE SHALL be ignored.

Reset
REQ-027 While reset=1 at an edge: state <= IDLE, pc <= RESET_PC, if_instr <= 0, if_pc <= 0, if_valid <= 0, halted <= 0, fetch_count <= 0.
REQ-028 Reset mid-operation (any state, any stall/branch) SHALL override all other inputs on that edge.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: fetch_count increments by 1 on every edge that sets if_valid <= 1 (REQ-019), saturates at 16'hFFFF, cleared by reset.
REQ-030 Macro FETCH_PERF_CNT_EN undefined: fetch_count port present, tied to 16'h0000, no counter flops.

Verification
REQ-031 Reset 2 cycles, release, memory word0=32'hAC230000 -> IDLE 1 cycle, next edge if_valid=1, if_instr=32'hAC230000, if_pc=0, direinstru=1.
REQ-032 Run from pc=30 no stall -> if_pc sequence 30, 31, 0, 1; direinstru wraps 31->0.
REQ-033 stall=1 for 3 cycles at pc=5 -> direinstru=5, if_pc=4 held 3 cycles, resume with if_pc=5.
REQ-034 branch_taken=1, branch_target=3, stall=1 same cycle at pc=8 -> next cycle if_valid=0, direinstru=3; following edge if_pc=3, if_valid=1.
REQ-035 halt_req=1 at pc=6 -> halted=1, if_valid=0, direinstru stays 6 for 10 cycles; reset -> pc=0, halted=0.
REQ-036 With FETCH_PERF_CNT_EN, 10 fetches incl. 2 stall cycles and 1 squash -> fetch_count=10; without macro -> fetch_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, IF/ID register, branch redirect and halt.
// Optional accepted-fetch performance counter is enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] direinstru,
    input  logic [DATA_W-1:0] instru,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LP_PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;
    logic              r_if_valid;
    logic              r_halted;
    logic              w_fetch;

    // An instruction is accepted only in RUN when nothing of higher priority intervenes.
    always_comb begin
        w_fetch = 1'b0;
        if (r_state == ST_RUN) begin
            w_fetch = ~halt_req & ~branch_taken & ~stall;
        end else begin
            w_fetch = 1'b0;
        end
    end

    // Fetch FSM, program counter and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= LP_RESET_PC;
            r_if_instr <= {DATA_W{1'b0}};
            r_if_pc    <= {ADDR_W{1'b0}};
            r_if_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Priority: halt over branch over stall.
                    if (halt_req) begin
                        r_state    <= ST_HALTED;
                        r_if_valid <= 1'b0;
                        r_halted   <= 1'b1;
                    end else if (branch_taken) begin
                        r_pc       <= branch_target;
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        r_if_instr <= instru;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= r_pc + LP_PC_ONE;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                ST_HALTED: begin
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_pc       <= LP_RESET_PC;
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_count;

    // Saturating count of accepted fetches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 16'h0000;
        end else if (w_fetch && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    logic w_fetch_unused;
    assign w_fetch_unused = w_fetch;
    assign fetch_count    = 16'h0000;
`endif

    assign direinstru = r_pc;
    assign if_instr   = r_if_instr;
    assign if_pc      = r_if_pc;
    assign if_valid   = r_if_valid;
    assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus randomized run against a reference model.
module tb_fetch_unit;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] direinstru;
    logic [DW-1:0] instru;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halt_req = 1'b0;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_valid;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [DW-1:0] mem [NW];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (0 = idle, 1 = running, 2 = halted)
    int          m_mode;
    int          m_pc;
    int          m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_valid;
    logic        m_halted;
    int          m_cnt;

    typedef struct {
        logic       rst;
        logic       stl;
        logic       br;
        logic [4:0] tgt;
        logic       hlt;
        logic [4:0] e_pc;
        logic       e_valid;
        logic [4:0] e_ifpc;
        logic       e_halted;
    } vec_t;

    vec_t tbl [$];

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .direinstru   (direinstru),
        .instru       (instru),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    assign instru = mem[direinstru];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic stl, input logic br, input logic [4:0] tgt,
                       input logic hlt, input logic [4:0] e_pc, input logic e_valid,
                       input logic [4:0] e_ifpc, input logic e_halted);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.hlt = hlt;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_ifpc = e_ifpc; v.e_halted = e_halted;
        tbl.push_back(v);
    endtask

    // Behavioural view: one clock edge of the fetch stage as seen from outside.
    task automatic model_edge(input logic rst, input logic stl, input logic br,
                              input logic [4:0] tgt, input logic hlt);
        if (rst) begin
            m_mode = 0; m_pc = 0; m_if_pc = 0; m_if_instr = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (hlt) begin
                m_mode = 2; m_valid = 1'b0; m_halted = 1'b1;
            end else if (br) begin
                m_pc = int'(tgt); m_valid = 1'b0;
            end else if (!stl) begin
                m_if_instr = mem[m_pc];
                m_if_pc    = m_pc;
                m_valid    = 1'b1;
                m_pc       = (m_pc + 1) % NW;
`ifdef FETCH_PERF_CNT_EN
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
            end
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [4:0] tgt, input logic hlt);
        reset = rst; stall = stl; branch_taken = br; branch_target = tgt; halt_req = hlt;
        @(posedge clk);
        model_edge(rst, stl, br, tgt, hlt);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = 32'hC0DE0000 + 32'(i);
        mem[0] = 32'hAC230000;

        // Reset, IDLE, then sequential fetch up to pc=5
        add(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        for (int i = 2; i <= 5; i++)
            add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 5'(i - 1), 1'b0);
        // Three stall cycles at pc=5
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd4, 1'b0);
        for (int i = 6; i <= 8; i++)
            add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 5'(i - 1), 1'b0);
        // Branch wins over stall at pc=8
        add(1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 5'd7, 1'b0);
        for (int i = 4; i <= 6; i++)
            add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 5'(i - 1), 1'b0);
        // Halt at pc=6 wins over branch/stall; frozen for 10 cycles
        add(1'b0, 1'b1, 1'b1, 5'd12, 1'b1, 5'd6, 1'b0, 5'd5, 1'b1);
        for (int i = 0; i < 10; i++)
            add(1'b0, 1'(i % 2), 1'(i % 3 == 0), 5'(20 + i), 1'(i % 4 == 1), 5'd6, 1'b0, 5'd5, 1'b1);
        // Reset out of HALTED; inputs ignored in IDLE; jump to 30 and wrap
        add(1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 5'd30, 1'b0, 5'd30, 1'b0, 5'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 5'd30, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 5'd1, 1'b0);
        // Reset in the middle of a running stream overrides everything
        add(1'b1, 1'b0, 1'b1, 5'd17, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);

        #2;
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].stl, tbl[k].br, tbl[k].tgt, tbl[k].hlt);
            chk($sformatf("tbl%0d.direinstru", k), 32'(direinstru), 32'(tbl[k].e_pc));
            chk($sformatf("tbl%0d.if_valid", k), 32'(if_valid), 32'(tbl[k].e_valid));
            chk($sformatf("tbl%0d.if_pc", k), 32'(if_pc), 32'(tbl[k].e_ifpc));
            chk($sformatf("tbl%0d.halted", k), 32'(halted), 32'(tbl[k].e_halted));
            chk($sformatf("tbl%0d.fetch_count", k), 32'(fetch_count), 32'(m_cnt));
            if (tbl[k].rst)
                chk($sformatf("tbl%0d.if_instr_rst", k), if_instr, 32'h0);
            else if (tbl[k].e_valid)
                chk($sformatf("tbl%0d.if_instr", k), if_instr, mem[tbl[k].e_ifpc]);
        end

        // Fetch count over a known mix: 10 fetches, 2 stalls, 1 squash
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 13; i++)
            step(1'b0, 1'(i == 3 || i == 4), 1'(i == 8), 5'd2, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf.fetch_count10", 32'(fetch_count), 32'd10);
`else
        chk("perf.fetch_count0", 32'(fetch_count), 32'd0);
`endif

        // Randomized run against the reference model with fresh memory contents
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0),
                 5'($urandom_range(0, NW - 1)),
                 1'($urandom_range(0, 79) == 0));
            chk("rnd.direinstru", 32'(direinstru), 32'(m_pc));
            chk("rnd.if_valid", 32'(if_valid), 32'(m_valid));
            chk("rnd.if_pc", 32'(if_pc), 32'(m_if_pc));
            chk("rnd.if_instr", if_instr, m_if_instr);
            chk("rnd.halted", 32'(halted), 32'(m_halted));
            chk("rnd.fetch_count", 32'(fetch_count), 32'(m_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
